multi_crack_ctrl: RTL and testbench

MULTI_CRACK_CTRL -- requirements
Module: multi_crack_ctrl

---
 rtl/multi_crack_ctrl.sv | 110 +++++++++++
 tb/tb_multi_crack_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_crack_ctrl.sv
// multi_crack_ctrl: brute-force key search controller feeding NUM_CH parallel decrypt cores.
// Define CRACK_PROGRESS_EN to add the saturating trials counter output.
module multi_crack_ctrl #(
    parameter int NUM_CH = 2,
    parameter int KEY_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid,
    output logic                    ready,
    output logic [KEY_W-1:0]        key,
    output logic                    key_valid,
    output logic [NUM_CH-1:0]       ch_valid,
    input  logic [NUM_CH-1:0]       ch_ready,
    output logic [NUM_CH*KEY_W-1:0] ch_key,
    input  logic [NUM_CH-1:0]       ch_pt_wren,
    input  logic [NUM_CH*8-1:0]     ch_pt_wrdata
`ifdef CRACK_PROGRESS_EN
    ,
    output logic [KEY_W:0]          trials
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} top_t;
    typedef enum logic [1:0] {C_IDLE, LAUNCH, BUSY, CHECK} ch_t;
    top_t state, state_nx;
    logic [NUM_CH-1:0] find, launch, ex;
    logic start, any_find;
    logic [KEY_W-1:0] win_key;
    assign start = state == IDLE && valid;
    assign ready = state == IDLE;
    assign any_find = |find;
    always_ff @(posedge clk)
        state <= !rst_n ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        if (state == IDLE) state_nx = valid ? RUN : IDLE;
        else if (state == RUN) state_nx = any_find || &ex ? DRAIN : RUN;
        else if (state == DRAIN) state_nx = &ch_ready && !(|ch_valid) ? IDLE : DRAIN;
        else state_nx = IDLE;
    end
    // Descending scan so the lowest-index finder is the last to write.
    always_comb begin
        win_key = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) if (find[j]) win_key = ch_key[j*KEY_W +: KEY_W];
    end
    always_ff @(posedge clk)
        if (!rst_n || start) begin
            key <= '0;
            key_valid <= 1'b0;
        end else if (any_find) begin
            key <= win_key;
            key_valid <= 1'b1;
        end
`ifdef CRACK_PROGRESS_EN
    localparam logic [KEY_W+1:0] T_MAX = (KEY_W+2)'(1) << KEY_W;
    logic [NUM_CH-1:0] in_check;
    logic [KEY_W+1:0] n_check, sum;
    always_comb begin
        n_check = '0;
        for (int j = 0; j < NUM_CH; j++) n_check = n_check + (KEY_W+2)'(in_check[j]);
    end
    assign sum = {1'b0, trials} + n_check;
    always_ff @(posedge clk)
        trials <= !rst_n || start ? '0 : sum > T_MAX ? T_MAX[KEY_W:0] : sum[KEY_W:0];
`endif
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_t cs, cs_nx;
        logic v, bd, x;
        logic [KEY_W-1:0] k;
        logic [KEY_W:0] k_nx;
        logic [7:0] b;
        assign b = ch_pt_wrdata[i*8 +: 8];
        assign k_nx = {1'b0, k} + (KEY_W+1)'(NUM_CH);
        assign find[i] = state == RUN && cs == CHECK && !bd;
        assign launch[i] = state == RUN && cs == LAUNCH && ch_ready[i] && !any_find;
        assign ch_valid[i] = v;
        assign ch_key[i*KEY_W +: KEY_W] = k;
        assign ex[i] = x;
`ifdef CRACK_PROGRESS_EN
        assign in_check[i] = cs == CHECK;
`endif
        always_comb begin
            cs_nx = cs;
            if (state == IDLE) cs_nx = valid ? LAUNCH : C_IDLE;
            else if (cs == LAUNCH) cs_nx = launch[i] ? BUSY : state == RUN ? LAUNCH : C_IDLE;
            else if (cs == BUSY) cs_nx = ch_ready[i] && !v ? CHECK : BUSY;
            else if (cs == CHECK) cs_nx = state == RUN && bd && !k_nx[KEY_W] ? LAUNCH : C_IDLE;
        end
        // An advance that carries into bit KEY_W would wrap, so the channel retires instead.
        always_ff @(posedge clk)
            if (!rst_n) begin
                cs <= C_IDLE;
                v <= 1'b0;
                bd <= 1'b0;
                x <= 1'b0;
                k <= '0;
            end else begin
                cs <= cs_nx;
                v <= launch[i];
                bd <= !launch[i] && (bd || (ch_pt_wren[i] && b != 8'd32 && (b < 8'd97 || b > 8'd122)));
                if (start) begin
                    k <= KEY_W'(i);
                    x <= 1'b0;
                end else if (state == RUN && cs == CHECK && bd) begin
                    if (k_nx[KEY_W]) x <= 1'b1;
                    else k <= k_nx[KEY_W-1:0];
                end
            end
    end
endmodule

// File: tb/tb_multi_crack_ctrl.sv
// tb_multi_crack_ctrl: self-checking bench with behavioural decrypt cores around several controller configurations.
module tb_multi_crack_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reset-only instance at full key width
    logic v24 = 1'b0, r24, kv24;
    logic [23:0] key24;
    logic [1:0] cv24;
    logic [47:0] ck24;
`ifdef CRACK_PROGRESS_EN
    logic [24:0] tr24;
`endif
    multi_crack_ctrl #(.NUM_CH(2), .KEY_W(24)) d24 (
        .clk(clk), .rst_n(rst_n), .valid(v24), .ready(r24), .key(key24), .key_valid(kv24),
        .ch_valid(cv24), .ch_ready(2'b11), .ch_key(ck24), .ch_pt_wren(2'b00), .ch_pt_wrdata(16'h0)
`ifdef CRACK_PROGRESS_EN
        , .trials(tr24)
`endif
    );

    // Two-channel instance with table-driven cores
    logic v2 = 1'b0, r2, kv2;
    logic [7:0] key2;
    logic [1:0] cv2, cr2, wr2;
    logic [15:0] ck2, wd2;
    int cn2[2];
    logic [7:0] cur2[2];
    int lat2[256];
    logic [7:0] pt2[256];
`ifdef CRACK_PROGRESS_EN
    logic [8:0] tr2;
`endif
    multi_crack_ctrl #(.NUM_CH(2), .KEY_W(8)) d2 (
        .clk(clk), .rst_n(rst_n), .valid(v2), .ready(r2), .key(key2), .key_valid(kv2),
        .ch_valid(cv2), .ch_ready(cr2), .ch_key(ck2), .ch_pt_wren(wr2), .ch_pt_wrdata(wd2)
`ifdef CRACK_PROGRESS_EN
        , .trials(tr2)
`endif
    );
    always @(posedge clk)
        for (int c = 0; c < 2; c++) begin
            wr2[c] <= 1'b0;
            if (!rst_n) begin cr2[c] <= 1'b1; cn2[c] <= 0; end
            else if (cv2[c]) begin cr2[c] <= 1'b0; cn2[c] <= lat2[ck2[c*8 +: 8]]; cur2[c] <= ck2[c*8 +: 8]; end
            else if (cn2[c] == 1) begin cn2[c] <= 0; cr2[c] <= 1'b1; wr2[c] <= 1'b1; wd2[c*8 +: 8] <= pt2[cur2[c]]; end
            else if (cn2[c] > 1) cn2[c] <= cn2[c] - 1;
        end

    // Three-channel instance, every key bad
    logic v3 = 1'b0, r3, kv3;
    logic [7:0] key3;
    logic [2:0] cv3, cr3, wr3;
    logic [23:0] ck3, wd3;
    int cn3[3];
`ifdef CRACK_PROGRESS_EN
    logic [8:0] tr3;
`endif
    multi_crack_ctrl #(.NUM_CH(3), .KEY_W(8)) d3 (
        .clk(clk), .rst_n(rst_n), .valid(v3), .ready(r3), .key(key3), .key_valid(kv3),
        .ch_valid(cv3), .ch_ready(cr3), .ch_key(ck3), .ch_pt_wren(wr3), .ch_pt_wrdata(wd3)
`ifdef CRACK_PROGRESS_EN
        , .trials(tr3)
`endif
    );
    always @(posedge clk)
        for (int c = 0; c < 3; c++) begin
            wr3[c] <= 1'b0;
            if (!rst_n) begin cr3[c] <= 1'b1; cn3[c] <= 0; end
            else if (cv3[c]) begin cr3[c] <= 1'b0; cn3[c] <= 2; end
            else if (cn3[c] == 1) begin cn3[c] <= 0; cr3[c] <= 1'b1; wr3[c] <= 1'b1; wd3[c*8 +: 8] <= 8'h01; end
            else if (cn3[c] > 1) cn3[c] <= cn3[c] - 1;
        end

    // Four-channel instance, keys 0x12 and 0x13 good with equal latency
    logic v4 = 1'b0, r4, kv4;
    logic [7:0] key4;
    logic [3:0] cv4, cr4, wr4;
    logic [31:0] ck4, wd4;
    int cn4[4];
    logic [7:0] cur4[4];
`ifdef CRACK_PROGRESS_EN
    logic [8:0] tr4;
`endif
    multi_crack_ctrl #(.NUM_CH(4), .KEY_W(8)) d4 (
        .clk(clk), .rst_n(rst_n), .valid(v4), .ready(r4), .key(key4), .key_valid(kv4),
        .ch_valid(cv4), .ch_ready(cr4), .ch_key(ck4), .ch_pt_wren(wr4), .ch_pt_wrdata(wd4)
`ifdef CRACK_PROGRESS_EN
        , .trials(tr4)
`endif
    );
    always @(posedge clk)
        for (int c = 0; c < 4; c++) begin
            wr4[c] <= 1'b0;
            if (!rst_n) begin cr4[c] <= 1'b1; cn4[c] <= 0; end
            else if (cv4[c]) begin cr4[c] <= 1'b0; cn4[c] <= 4; cur4[c] <= ck4[c*8 +: 8]; end
            else if (cn4[c] == 1) begin
                cn4[c] <= 0; cr4[c] <= 1'b1; wr4[c] <= 1'b1;
                wd4[c*8 +: 8] <= (cur4[c] == 8'h12 || cur4[c] == 8'h13) ? "k" : "Z";
            end else if (cn4[c] > 1) cn4[c] <= cn4[c] - 1;
        end

    // Scoreboard: expected d2 result pushed at start, popped when ready rises
    typedef struct { logic [7:0] key; logic kv; } res_t;
    res_t sb[$];
    res_t e;
    logic r2_q = 1'b1, ch0_35 = 1'b0;
    int launches3[256];
    always @(negedge clk) begin
        if (r2 && !r2_q && sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_key", key2, e.key);
            chk("sb_key_valid", kv2, e.kv);
        end
        r2_q <= r2;
        if (cv2[0] && ck2[7:0] == 8'h35) ch0_35 <= 1'b1;
        for (int c = 0; c < 3; c++) if (cv3[c]) launches3[ck3[c*8 +: 8]] <= launches3[ck3[c*8 +: 8]] + 1;
    end

    task automatic start2();
        @(negedge clk); v2 = 1'b1;
        @(negedge clk); v2 = 1'b0;
    endtask

    task automatic wait_sb(input int budget);
        for (int n = 0; n < budget && sb.size() > 0; n++) @(negedge clk);
        chk("sb_timeout_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic fill2(input logic [7:0] p, input int l);
        for (int j = 0; j < 256; j++) begin pt2[j] = p; lat2[j] = l; end
    endtask

    typedef struct { logic [7:0] pt; logic [7:0] exp_key; } vec_t;
    vec_t tbl[10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int bad_cnt, hi_cnt, n;
        tbl = '{'{8'd32, 8'd0}, '{8'd97, 8'd0}, '{8'd122, 8'd0}, '{8'd110, 8'd0},
                '{8'd31, 8'd1}, '{8'd33, 8'd1}, '{8'd96, 8'd1}, '{8'd123, 8'd1},
                '{8'd65, 8'd1}, '{8'd255, 8'd1}};
        fill2(8'h01, 3);
        repeat (2) @(negedge clk);
        chk("rst_ready", r24, 1);
        chk("rst_key_valid", kv24, 0);
        chk("rst_ch_valid", cv24, 0);
        chk("rst_key", key24, 0);
        chk("rst_ch_key", ck24[31:0], 0);
        chk("rst_ready_d2", r2, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Plaintext byte classification: key 0 carries the table byte, key 1 is good but slower
        for (int t = 0; t < 10; t++) begin
            fill2(8'h01, 3);
            pt2[0] = tbl[t].pt;
            pt2[1] = "a";
            lat2[1] = 10;
            sb.push_back('{tbl[t].exp_key, 1'b1});
            start2();
            wait_sb(300);
        end

        // Single find at 0x35
        fill2(8'h01, 3);
        pt2[8'h35] = "q";
        sb.push_back('{8'h35, 1'b1});
        start2();
        chk("start_clears_key_valid", kv2, 0);
        chk("start_drops_ready", r2, 0);
        wait_sb(2000);
        chk("single_cores_idle", cr2, 2'b11);
        chk("ch0_never_0x35", ch0_35, 0);
        repeat (5) @(negedge clk);
        chk("single_key_hold", key2, 8'h35);
        chk("single_kv_hold", kv2, 1);

        // Drain: ch1 finds key 3 while ch0 is busy ~60 cycles on key 2 (also good)
        fill2(8'h01, 3);
        pt2[2] = "a";
        pt2[3] = "a";
        lat2[2] = 60;
        sb.push_back('{8'h03, 1'b1});
        start2();
        for (n = 0; n < 200 && !kv2; n++) @(negedge clk);
        chk("drain_find_seen", kv2, 1);
        hi_cnt = 0;
        v2 = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (r2) hi_cnt++;
        end
        v2 = 1'b0;
        chk("drain_ready_low", hi_cnt, 0);
        chk("drain_ch0_busy", cr2[0], 0);
        chk("drain_key_during", key2, 8'h03);
        wait_sb(300);
        repeat (5) @(negedge clk);
        chk("drain_late_find_ignored", key2, 8'h03);
        chk("drain_ready_after", r2, 1);

        // Exhaustion on three channels
        @(negedge clk); v3 = 1'b1;
        @(negedge clk); v3 = 1'b0;
        for (n = 0; n < 3000 && !r3; n++) @(negedge clk);
        chk("exh_done", r3, 1);
        chk("exh_key_valid", kv3, 0);
        chk("exh_key", key3, 0);
        bad_cnt = 0;
        for (int j = 0; j < 256; j++) if (launches3[j] != 1) bad_cnt++;
        chk("exh_keys_not_once", bad_cnt, 0);
        chk("exh_key255_once", launches3[255], 1);
`ifdef CRACK_PROGRESS_EN
        chk("exh_trials", tr3, 256);
`endif

        // Simultaneous finds on four channels
        @(negedge clk); v4 = 1'b1;
        @(negedge clk); v4 = 1'b0;
        chk("simul_ready_dropped", r4, 0);
        for (n = 0; n < 500 && !r4; n++) @(negedge clk);
        chk("simul_done", r4, 1);
        chk("simul_key", key4, 8'h12);
        chk("simul_key_valid", kv4, 1);

        // Mid-run reset, then restart from keys 0 and 1
        fill2(8'h01, 20);
        start2();
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("midrst_ch_valid", cv2, 0);
            chk("midrst_ready", r2, 1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_pulse", cv2, 0);
        start2();
        for (n = 0; n < 20 && cv2 == 2'b00; n++) @(negedge clk);
        chk("restart_both_launch", cv2, 2'b11);
        chk("restart_ch0_key", ck2[7:0], 8'h00);
        chk("restart_ch1_key", ck2[15:8], 8'h01);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
